// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Bundle of signals between the instruction-fetch stage and its
//               surroundings: EX-stage redirect, hazard stall, busywait
//               instruction memory, and the IF/ID pipeline register outputs.
//   master (fetch unit) inputs : branch_sel, b_pc, stall, imem_busy,
//                                imem_readdata
//   master (fetch unit) outputs: imem_read, imem_addr, ifid_pc, ifid_pc4,
//                                ifid_instr, ifid_valid, flush
//   slave  : mirror image of master
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if;
  logic        branch_sel;
  logic [31:0] b_pc;
  logic        stall;
  logic        imem_busy;
  logic [31:0] imem_readdata;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        flush;

  modport master (
    input  branch_sel, b_pc, stall, imem_busy, imem_readdata,
    output imem_read, imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid,
           flush
  );

  modport slave (
    output branch_sel, b_pc, stall, imem_busy, imem_readdata,
    input  imem_read, imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid,
           flush
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : RV32IM instruction-fetch stage. Owns the PC, drives a busywait
//               instruction memory and loads the IF/ID register. Redirects
//               from EX squash the wrong-path fetch; a redirect arriving while
//               the memory is busy parks the target and waits (DRAIN) for the
//               abandoned access to finish before fetching the target.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_fetch_unit_if.master (redirect, stall, imem, IF/ID, flush)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire              clk,
  input  wire              rst,
  pc_fetch_unit_if.master  bus
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_redir_pc;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;

  // Redirect targets are always word aligned.
  logic [31:0] w_target;
  assign w_target = {bus.b_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_redir_pc   <= 32'h0000_0000;
      r_ifid_pc    <= 32'h0000_0000;
      r_ifid_pc4   <= 32'h0000_0000;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (bus.branch_sel) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
            if (bus.imem_busy) begin
              // Memory is mid-access on the wrong path: it keeps its latched
              // address, so park the target until the access completes.
              r_redir_pc <= w_target;
              r_state    <= ST_DRAIN;
            end else begin
              r_pc <= w_target;
            end
          end else if (bus.stall) begin
            // Hold everything; returned data is dropped and refetched later.
          end else if (bus.imem_busy) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= NOP_INSTR;
          end else begin
            r_ifid_pc    <= r_pc;
            r_ifid_pc4   <= r_pc + 32'd4;
            r_ifid_instr <= bus.imem_readdata;
            r_ifid_valid <= 1'b1;
            r_pc         <= r_pc + 32'd4;
          end
        end
        ST_DRAIN: begin
          // Whatever the abandoned access returns is wrong-path data.
          r_ifid_valid <= 1'b0;
          r_ifid_instr <= NOP_INSTR;
          if (bus.branch_sel) begin
            if (bus.imem_busy) begin
              r_redir_pc <= w_target;
            end else begin
              r_pc    <= w_target;
              r_state <= ST_FETCH;
            end
          end else if (!bus.imem_busy) begin
            r_pc    <= r_redir_pc;
            r_state <= ST_FETCH;
          end
        end
        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_read  = ~rst;
  assign bus.imem_addr  = r_pc;
  assign bus.flush      = bus.branch_sel & ~rst;
  assign bus.ifid_pc    = r_ifid_pc;
  assign bus.ifid_pc4   = r_ifid_pc4;
  assign bus.ifid_instr = r_ifid_instr;
  assign bus.ifid_valid = r_ifid_valid;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_unit
// Description : Scoreboard bench for pc_fetch_unit. A driver issues directed
//               and random cycles, runs a transaction-level model of the fetch
//               stage and queues the expected IF/ID contents and next fetch
//               address; a monitor pops and compares after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk;
  logic rst;
  pc_fetch_unit_if bus();

  pc_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Memory contents: a fixed, address-dependent word, never equal to NOP here.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: where the program counter is, whether a wrong-path memory
  // access is still being waited out, and where to go once it finishes.
  logic [31:0] m_pc, m_tgt, m_ipc, m_ipc4, m_instr;
  logic        m_valid, m_abandon;

  task automatic step(input logic r, input logic b, input logic [31:0] bp,
                      input logic s, input logic bsy);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.branch_sel    = b;
    bus.b_pc          = bp;
    bus.stall         = s;
    bus.imem_busy     = bsy;
    bus.imem_readdata = bsy ? $urandom : mem_word(bus.imem_addr);
    #1;
    chk("flush", {31'd0, bus.flush}, {31'd0, b & ~r});
    chk("imem_read", {31'd0, bus.imem_read}, {31'd0, ~r});

    if (r) begin
      m_pc = RESET_PC; m_tgt = 32'd0; m_abandon = 1'b0;
      m_ipc = 32'd0; m_ipc4 = 32'd0; m_instr = NOP_INSTR; m_valid = 1'b0;
    end else if (m_abandon || b) begin
      m_valid = 1'b0; m_instr = NOP_INSTR;
      if (b && bsy) begin
        m_tgt = bp & ~32'd3; m_abandon = 1'b1;
      end else if (b) begin
        m_pc = bp & ~32'd3; m_abandon = 1'b0;
      end else if (!bsy) begin
        m_pc = m_tgt; m_abandon = 1'b0;
      end
    end else if (s) begin
      // stalled: nothing moves
    end else if (bsy) begin
      m_valid = 1'b0; m_instr = NOP_INSTR;
    end else begin
      m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
      m_instr = mem_word(m_pc); m_pc = m_pc + 32'd4;
    end
    e.valid = m_valid; e.pc = m_ipc; e.pc4 = m_ipc4;
    e.instr = m_instr; e.addr = m_pc;
    q.push_back(e);
  endtask

  // Monitor: after each edge the DUT presents a new IF/ID word and fetch address.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ifid_valid", {31'd0, bus.ifid_valid}, {31'd0, e.valid});
      chk("ifid_instr", bus.ifid_instr, e.instr);
      chk("imem_addr", bus.imem_addr, e.addr);
      if (e.valid) begin
        chk("ifid_pc", bus.ifid_pc, e.pc);
        chk("ifid_pc4", bus.ifid_pc4, e.pc4);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp;
    rst = 1'b1;
    bus.branch_sel = 1'b0; bus.b_pc = 32'd0; bus.stall = 1'b0;
    bus.imem_busy = 1'b0; bus.imem_readdata = 32'd0;
    m_pc = RESET_PC; m_tgt = 0; m_abandon = 0; m_ipc = 0; m_ipc4 = 0;
    m_instr = NOP_INSTR; m_valid = 0;

    // Reset for two cycles with idle memory.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    // Sequential fetch, two wait states on the second word.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Get to PC=0x20, then redirect to unaligned 0x103 with idle memory.
    step(0, 1, 32'h20, 0, 0);
    step(0, 1, 32'h103, 0, 0);
    step(0, 0, 0, 0, 0);
    // Redirect in the middle of a 3-cycle busy access at 0x40.
    step(0, 1, 32'h40, 0, 0);
    step(0, 1, 32'h200, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // Stall together with redirect, then stall alone for two cycles.
    step(0, 1, 32'h80, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // Reset while draining an abandoned access.
    step(0, 1, 32'h300, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFF, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bp = $urandom;
      if ($urandom_range(0, 3) == 0) bp = 32'hFFFF_FFF0 | (bp & 32'hF);
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 7) == 0), bp,
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0));
    end

    step(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the RV32IM pipeline: owns the program counter, drives the busywait instruction memory, and loads the IF/ID pipeline register. It consumes the redirect request (BRANCH_SEL, B_PC) produced by the EX-stage branch/jump controller, squashes wrong-path fetches, and safely abandons a fetch already in flight when a redirect arrives mid-access.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, encoding placed in IFID_INSTR for bubbles (addi x0,x0,0).

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- BRANCH_SEL  in  1  redirect request from EX-stage branch/jump controller.
- B_PC  in  32  redirect target.
- STALL  in  1  hazard-unit hold of PC and IF/ID (load-use).
- IMEM_BUSY  in  1  instruction memory busywait; data valid in a cycle with IMEM_READ=1 and IMEM_BUSY=0.
- IMEM_READDATA  in  32  fetched instruction.
- IMEM_READ  out  1  fetch request.
- IMEM_ADDR  out  32  fetch address.
- IFID_PC  out  32  PC of instruction in IF/ID.
- IFID_PC4  out  32  IFID_PC + 4.
- IFID_INSTR  out  32  instruction in IF/ID.
- IFID_VALID  out  1  IF/ID holds a real instruction.
- FLUSH  out  1  kill ID/EX contents this edge (redirect taken).

## Operation
- State: PC (32), REDIR_PC (32), FSM {FETCH, DRAIN}.
- IMEM_READ = ~RESET. IMEM_ADDR = PC (both states; memory holds its latched address until IMEM_BUSY drops).
- FLUSH = BRANCH_SEL & ~RESET, combinational.
- Every value loaded into PC/REDIR_PC from B_PC has bits [1:0] forced to 00.
- Priority per edge: RESET > BRANCH_SEL > STALL > normal fetch.
- FETCH, BRANCH_SEL=1, IMEM_BUSY=0: PC<=B_PC; IFID_VALID<=0, IFID_INSTR<=NOP_INSTR; stay FETCH.
- FETCH, BRANCH_SEL=1, IMEM_BUSY=1: REDIR_PC<=B_PC; PC held; IFID bubble; ->DRAIN.
- FETCH, STALL=1 (no redirect): PC and all IFID_* held; any data returned this cycle is discarded (same address refetched).
- FETCH, IMEM_BUSY=1 (no redirect/stall): PC held; IFID bubble.
- FETCH, IMEM_BUSY=0 (no redirect/stall): IFID_PC<=PC, IFID_PC4<=PC+4, IFID_INSTR<=IMEM_READDATA, IFID_VALID<=1; PC<=PC+4 (mod 2^32, wraps FFFF_FFFC->0000_0000).
- DRAIN: IFID bubble every cycle regardless of STALL; returned data always discarded. BRANCH_SEL=1 overwrites REDIR_PC with new B_PC. When IMEM_BUSY=0 (and no redirect that cycle): PC<=REDIR_PC, ->FETCH. BRANCH_SEL=1 together with IMEM_BUSY=0: PC<=B_PC, ->FETCH.
- IFID bubble = IFID_VALID<=0, IFID_INSTR<=NOP_INSTR; IFID_PC/IFID_PC4 don't care but held.

## Timing
- Reset values: PC=RESET_PC, REDIR_PC=0, FSM=FETCH, IFID_PC=0, IFID_PC4=0, IFID_INSTR=NOP_INSTR, IFID_VALID=0; IMEM_READ=0 and FLUSH=0 while RESET=1.
- RESET mid-DRAIN: return to FETCH at RESET_PC; pending target dropped; memory completes abandoned access on its own.
- Zero-wait memory: one instruction per cycle; fetch-to-IF/ID latency 1 edge.
- Redirect penalty with zero-wait memory: 2 bubbles (wrong-path instruction in IF/ID killed by bubble, ID/EX killed via FLUSH); target in IF/ID one edge after the redirect edge.
- Redirect during busy access: target fetch starts in cycle after IMEM_BUSY falls.
- No combinational path from IMEM_READDATA to any output.

## Test plan
- Reset: hold RESET 2 cycles, IMEM_BUSY=0 -> IMEM_READ=0, IFID_VALID=0, IFID_INSTR=0000_0013; first edge after release IFID_PC=0000_0000, IFID_PC4=0000_0004, VALID=1.
- Sequential + busy: memory returns 3 words, 2 wait cycles on the 2nd -> IFID_PC 0,(bubble,bubble),4,8; PC never skips.
- Redirect idle memory: BRANCH_SEL=1, B_PC=0000_0103 at PC=0x20 -> FLUSH=1 that cycle, IF/ID bubble, next fetch address 0000_0100.
- Redirect mid-access: IMEM_BUSY=1 for 3 cycles at PC=0x40, BRANCH_SEL pulse B_PC=0x200 in cycle 1 -> IMEM_ADDR stays 0x40 until busy drops, returned word discarded, next IMEM_ADDR=0x200, VALID=0 throughout DRAIN.
- STALL with BRANCH_SEL same cycle: B_PC=0x80 -> redirect wins, PC=0x80, bubble; STALL alone holds IFID_* unchanged for 2 cycles.
- Reset in DRAIN and PC wrap: RESET during DRAIN -> PC=RESET_PC, FSM=FETCH; redirect to FFFF_FFFC then fetch -> next IMEM_ADDR 0000_0000.
